system_keys: RTL and testbench

Avalon-MM slave input port that samples a bank of external push-buttons/switches, synchronizes them and optionally debounces them. It latches edges in a sticky capture register and raises a maskable interrupt. It is the input-direction companion of the system's output display port: same slave bus, same zero-wait-state read behaviour. It sits between the board key pins and the Nios II data master and IRQ line.

---
 rtl/system_keys_pkg.sv | 17 +
 rtl/system_keys_debounce.sv | 60 ++++++
 rtl/system_keys.sv | 99 +++++++++
 tb/tb_system_keys.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_keys_pkg.sv
// system_keys_pkg: register map and edge-type encoding shared by the
// system_keys input port and its per-bit input conditioner.
package system_keys_pkg;

   // Word addresses on the slave bus (address 1 is reserved)
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Which transition of the filtered input sets a capture bit
   typedef enum logic [1:0] {
      EDGE_FALL = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage

// File: rtl/system_keys_debounce.sv
// system_keys_debounce: one input bit -> 2-flop synchronizer -> filter.
// With SYSTEM_KEYS_DEBOUNCE_EN defined the filter is a stability counter
// that only accepts a new level after DEBOUNCE_CYCLES consecutive clocks
// of disagreement (DEBOUNCE_CYCLES must be >= 1); otherwise the filter is
// a straight pass-through of the synchronizer output.
module system_keys_debounce
   import system_keys_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic filt
);

   logic sync1_reg;
   logic sync2_reg;

   // Two-stage synchronizer for the asynchronous pin, preset to the idle level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= IDLE_LEVEL;
         sync2_reg <= IDLE_LEVEL;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef SYSTEM_KEYS_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] count_reg;
   logic          filt_reg;

   // Count clocks of disagreement; any agreement restarts the count, and the
   // last count of a full run commits the new level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
         filt_reg  <= IDLE_LEVEL;
      end else if (sync2_reg == filt_reg) begin
         count_reg <= '0;
      end else if (count_reg == LAST) begin
         filt_reg  <= sync2_reg;
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign filt = filt_reg;
`else
   assign filt = sync2_reg;
`endif

endmodule

// File: rtl/system_keys.sv
// system_keys: Avalon-MM slave input port for board keys/switches.
// Synchronizes (and, with SYSTEM_KEYS_DEBOUNCE_EN defined, debounces) the
// inputs, latches selected edges into a write-1-to-clear capture register
// and drives a level IRQ gated by a mask. Reads are zero-wait-state.
module system_keys
   import system_keys_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int EDGE_TYPE       = 0,
   parameter int IDLE_LEVEL      = 1,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic             IDLE_BIT  = (IDLE_LEVEL != 0);
   localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};
   localparam edge_type_e       ETYPE     = edge_type_e'(EDGE_TYPE[1:0]);

   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] irqmask_reg;
   logic [WIDTH-1:0] edgecap_reg;
   logic [WIDTH-1:0] edges;
   logic [WIDTH-1:0] clear_bits;
   logic             wr;
   logic             unused_bits;

   // Upper write-data bits beyond WIDTH carry no meaning
   assign unused_bits = ^writedata;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         system_keys_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (IDLE_BIT)
         ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[gi]),
            .filt  (filt[gi])
         );
      end
   endgenerate

   assign wr         = chipselect & ~write_n;
   assign clear_bits = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   // Per-bit edge detect between the filtered value and its one-clock delay
   always_comb begin
      edges = '0;
      case (ETYPE)
         EDGE_FALL: edges = prev_reg & ~filt;
         EDGE_RISE: edges = ~prev_reg & filt;
         default:   edges = prev_reg ^ filt;
      endcase
   end

   // One-clock delay of the filtered inputs; idle preset avoids a reset edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_reg <= IDLE_WORD;
      else       prev_reg <= filt;
   end

   // Interrupt mask register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               irqmask_reg <= '0;
      else if (wr && address == ADDR_IRQMASK)  irqmask_reg <= writedata[WIDTH-1:0];
   end

   // Sticky edge capture; a new edge beats a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) edgecap_reg <= '0;
      else       edgecap_reg <= (edgecap_reg & ~clear_bits) | edges;
   end

   assign irq = |(edgecap_reg & irqmask_reg);

   // Zero-latency read mux; reserved address reads as zero
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = filt;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_reg;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_reg;
         default:      readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_system_keys.sv
// tb_system_keys: scenario tasks plus randomized traffic for system_keys
// (WIDTH=4, falling edges, active-low keys, DEBOUNCE_CYCLES=8), checked
// against a cycle-level behavioural model of the port.
module tb_system_keys;

   localparam int W  = 4;
   localparam int DC = 8;
`ifdef SYSTEM_KEYS_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif
   localparam int SETTLE = DEB ? DC + 6 : 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata;
   logic          irq;

   int checks = 0;
   int fails  = 0;

   // model state: synchronizer stages, filtered value, delayed value, registers
   logic [W-1:0] m_s1, m_s2, m_filt, m_prev, m_cap, m_mask;
   int           m_run [W];

   always #5 clk = ~clk;

   system_keys #(
      .WIDTH           (W),
      .EDGE_TYPE       (0),
      .IDLE_LEVEL      (1),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_filt = '1; m_prev = '1;
      m_cap = '0; m_mask = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {28'h0, m_filt};
         2'd2:    return {28'h0, m_mask};
         2'd3:    return {28'h0, m_cap};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic exp_irq();
      return |(m_cap & m_mask);
   endfunction

   // Advance one clock: both DUT and model see the inputs held over the edge
   task automatic step();
      logic         wr;
      logic [W-1:0] clr, edg, n_filt;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         wr  = chipselect && !write_n;
         clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
         edg = '0;
         for (int i = 0; i < W; i++)
            if (m_prev[i] == 1'b1 && m_filt[i] == 1'b0) edg[i] = 1'b1;
         n_filt = m_filt;
         if (DEB) begin
            for (int i = 0; i < W; i++) begin
               if (m_s2[i] != m_filt[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] >= DC) begin
                     n_filt[i] = m_s2[i];
                     m_run[i]  = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
         end else begin
            n_filt = m_s1;
         end
         if (wr && address == 2'd2) m_mask = writedata[W-1:0];
         m_cap  = (m_cap & ~clr) | edg;
         m_prev = m_filt;
         m_filt = n_filt;
         m_s2   = m_s1;
         m_s1   = in_port;
      end
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      $display("[%0t] write addr=%0d data=0x%08h", $time, a, d);
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
      address = 2'd0; writedata = '0;
      model_reset();
      step(); step();
      for (int a = 0; a < 4; a++) begin
         address = a[1:0]; #1;
         checks++;
         if (readdata !== exp_rd(a[1:0])) begin
            fails++;
            $display("FAIL reset_read@%0d: got 0x%08h want 0x%08h", a, readdata, exp_rd(a[1:0]));
         end
      end
      checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_irq: irq=%b want 0", irq);
      end
      reset = 1'b0;
      for (int c = 0; c < 10; c++) step();
      address = 2'd3; #1;
      checks++;
      if (readdata !== exp_rd(2'd3) || irq !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_capture: cap=0x%08h irq=%b want 0x%08h 0", readdata, irq, exp_rd(2'd3));
      end
      $display("[%0t] reset scenario done", $time);
   endtask

   task automatic test_edge_irq();
      bus_write(2'd2, 32'h2);
      in_port = 4'b1101;
      for (int c = 0; c < SETTLE; c++) begin
         step();
         checks++;
         if (irq !== exp_irq()) begin
            fails++;
            $display("FAIL edge_irq_cycle%0d: irq=%b want %b", c, irq, exp_irq());
         end
      end
      address = 2'd3; #1;
      checks++;
      if (readdata !== 32'h2 || readdata !== exp_rd(2'd3) || irq !== 1'b1) begin
         fails++;
         $display("FAIL edge_capture_bit1: cap=0x%08h irq=%b want 0x00000002 1", readdata, irq);
      end
      bus_write(2'd3, 32'h2);
      address = 2'd3; #1;
      checks++;
      if (readdata !== exp_rd(2'd3) || irq !== exp_irq()) begin
         fails++;
         $display("FAIL clear_bit1: cap=0x%08h irq=%b want 0x%08h %b", readdata, irq, exp_rd(2'd3), exp_irq());
      end
   endtask

   task automatic test_mask_late();
      in_port = 4'b1100;
      for (int c = 0; c < SETTLE; c++) step();
      address = 2'd3; #1;
      checks++;
      if (readdata !== exp_rd(2'd3) || irq !== 1'b0) begin
         fails++;
         $display("FAIL unmasked_capture: cap=0x%08h irq=%b want 0x%08h 0", readdata, irq, exp_rd(2'd3));
      end
      bus_write(2'd2, 32'h1);
      checks++;
      if (irq !== exp_irq() || irq !== 1'b1) begin
         fails++;
         $display("FAIL mask_enables_irq: irq=%b want 1", irq);
      end
      bus_write(2'd3, 32'hF);
      checks++;
      if (irq !== exp_irq()) begin
         fails++;
         $display("FAIL clear_all: irq=%b want %b", irq, exp_irq());
      end
   endtask

   task automatic test_set_wins();
      bit found = 1'b0;
      in_port = 4'hF;
      for (int c = 0; c < SETTLE; c++) step();
      in_port = 4'hE;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (m_prev[0] && !m_filt[0]) found = 1'b1;
      end
      checks++;
      if (!found) begin
         fails++;
         $display("FAIL set_wins_timeout: no bit0 edge within 40 clocks");
      end else begin
         bus_write(2'd3, 32'h1);
         address = 2'd3; #1;
         checks++;
         if (readdata[0] !== 1'b1 || readdata !== exp_rd(2'd3)) begin
            fails++;
            $display("FAIL set_beats_clear: cap=0x%08h want bit0=1 (0x%08h)", readdata, exp_rd(2'd3));
         end
      end
   endtask

   task automatic test_debounce_glitch();
      in_port = 4'hF;
      for (int c = 0; c < SETTLE; c++) step();
      bus_write(2'd3, 32'hF);
      in_port = 4'b1011;
      for (int c = 0; c < 5; c++) step();
      in_port = 4'hF;
      for (int c = 0; c < SETTLE; c++) begin
         step();
         address = 2'd0; #1;
         checks++;
         if (readdata !== exp_rd(2'd0)) begin
            fails++;
            $display("FAIL glitch_data_c%0d: got 0x%08h want 0x%08h", c, readdata, exp_rd(2'd0));
         end
      end
      address = 2'd3; #1;
      checks++;
      if (readdata !== exp_rd(2'd3)) begin
         fails++;
         $display("FAIL glitch_capture: got 0x%08h want 0x%08h", readdata, exp_rd(2'd3));
      end
      bus_write(2'd3, 32'hF);
      in_port = 4'b1011;
      for (int c = 0; c < SETTLE; c++) step();
      address = 2'd0; #1;
      checks++;
      if (readdata !== 32'hB || readdata !== exp_rd(2'd0)) begin
         fails++;
         $display("FAIL stable_low_data: got 0x%08h want 0x0000000b", readdata);
      end
      address = 2'd3; #1;
      checks++;
      if (readdata !== 32'h4 || readdata !== exp_rd(2'd3)) begin
         fails++;
         $display("FAIL stable_low_capture: got 0x%08h want 0x00000004", readdata);
      end
   endtask

   task automatic test_async_reset();
      bus_write(2'd2, 32'hF);
      in_port = 4'b0111;
      for (int c = 0; c < 4; c++) step();
      reset = 1'b1; #1;
      model_reset();
      for (int a = 0; a < 4; a++) begin
         address = a[1:0]; #1;
         checks++;
         if (readdata !== exp_rd(a[1:0])) begin
            fails++;
            $display("FAIL async_reset_read@%0d: got 0x%08h want 0x%08h", a, readdata, exp_rd(a[1:0]));
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_irq: irq=%b want 0", irq);
      end
      in_port = 4'hF;
      step();
      reset = 1'b0;
      for (int c = 0; c < SETTLE; c++) step();
      bus_write(2'd0, 32'h0);
      bus_write(2'd1, 32'hF);
      for (int a = 0; a < 4; a++) begin
         address = a[1:0]; #1;
         checks++;
         if (readdata !== exp_rd(a[1:0])) begin
            fails++;
            $display("FAIL ignored_write_read@%0d: got 0x%08h want 0x%08h", a, readdata, exp_rd(a[1:0]));
         end
      end
   endtask

   task automatic test_random();
      int op;
      logic [1:0] ra;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 15) == 0) in_port = W'($urandom);
         op = $urandom_range(0, 19);
         if (op < 3)       bus_write(2'd2, $urandom);
         else if (op < 7)  bus_write(2'd3, $urandom);
         else if (op == 7) bus_write(2'($urandom_range(0, 1)), $urandom);
         else              step();
         ra = 2'($urandom);
         address = ra; #1;
         checks++;
         if (readdata !== exp_rd(ra) || irq !== exp_irq()) begin
            fails++;
            $display("FAIL random_n%0d@%0d: rd=0x%08h irq=%b want 0x%08h %b",
                     n, ra, readdata, irq, exp_rd(ra), exp_irq());
         end
      end
      $display("[%0t] random traffic done", $time);
   endtask

   initial begin
      test_reset();
      test_edge_irq();
      test_mask_late();
      test_set_wins();
      test_debounce_glitch();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
